key_click_decoder: RTL and testbench

- Sits directly downstream of the key debouncer. Consumes its 1-cycle press pulse, already synchronous to CLK1K.
- Groups presses that fall within a gap window into single, double or triple click events.
- Queues each classified event in a 4-deep FIFO. The control logic pops the FIFO with a valid/ready handshake.

---
 rtl/key_click_decoder.sv | 145 ++++++++++++++
 tb/tb_key_click_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// key_click_decoder: groups debounced key press pulses into single/double/triple
// click events and queues them in a 4-deep FIFO drained by a valid/ready consumer.
module key_click_decoder #(
    parameter int WINDOW     = 250,
    parameter int MAX_CLICKS = 3
) (
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic       KEY_PULSE,
    input  logic       EVT_READY,
    input  logic       OVF_CLR,
    output logic       EVT_VALID,
    output logic [1:0] EVT_CODE,
    output logic       BUSY,
    output logic       OVERFLOW
);

    localparam logic [9:0] TMR_LAST = 10'(WINDOW - 1);
    localparam logic [1:0] MAX_CODE = 2'(MAX_CLICKS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;
    logic [9:0]  r_timer;
    logic [9:0]  w_timer_nxt;
    logic        w_emit;
    logic [1:0]  w_emit_code;

    logic [1:0]  r_mem [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_occ;
    logic        r_ovf;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_drop;

    // Click grouping: next state, count, gap timer and the event to emit.
    // A pulse in WAIT is evaluated before the expiry test, so it wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_timer_nxt = r_timer;
        w_emit      = 1'b0;
        w_emit_code = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (KEY_PULSE) begin
                    w_count_nxt = 2'd1;
                    w_timer_nxt = 10'd0;
                    if (MAX_CLICKS == 1) begin
                        w_emit      = 1'b1;
                        w_emit_code = 2'd1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (KEY_PULSE) begin
                    w_count_nxt = r_count + 2'd1;
                    w_timer_nxt = 10'd0;
                    if ((r_count + 2'd1) == MAX_CODE) begin
                        w_emit      = 1'b1;
                        w_emit_code = MAX_CODE;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_emit      = 1'b1;
                    w_emit_code = r_count;
                    w_timer_nxt = 10'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 10'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grouping state register.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_count <= 2'd0;
            r_timer <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = (r_occ != 3'd0) && EVT_READY;
    assign w_full = (r_occ == 3'd4);
    assign w_push = w_emit && (!w_full || w_pop);
    assign w_drop = w_emit && w_full && !w_pop;

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_occ  <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset.
    always_ff @(posedge CLK1K) begin
        if (w_push) r_mem[r_wptr] <= w_emit_code;
    end

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (OVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end

    assign EVT_VALID = (r_occ != 3'd0);
    assign EVT_CODE  = EVT_VALID ? r_mem[r_rptr] : 2'd0;
    assign BUSY      = (r_state == ST_WAIT);
    assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: scenario tasks for key_click_decoder (WINDOW=250, MAX_CLICKS=3).
// Expected event codes are queued when a group is stimulated and compared on pop.
module tb_key_click_decoder;

    logic       CLK1K;
    logic       RSTN;
    logic       KEY_PULSE;
    logic       EVT_READY;
    logic       OVF_CLR;
    logic       EVT_VALID;
    logic [1:0] EVT_CODE;
    logic       BUSY;
    logic       OVERFLOW;

    int         checks;
    int         failures;
    int         cyc;
    logic [1:0] exp_q[$];

    key_click_decoder #(.WINDOW(250), .MAX_CLICKS(3)) dut (
        .CLK1K     (CLK1K),
        .RSTN      (RSTN),
        .KEY_PULSE (KEY_PULSE),
        .EVT_READY (EVT_READY),
        .OVF_CLR   (OVF_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_CODE  (EVT_CODE),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK1K = 1'b0;
    always #5 CLK1K = ~CLK1K;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK1K);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse();
        KEY_PULSE = 1'b1;
        tick();
        KEY_PULSE = 1'b0;
    endtask

    task automatic do_reset();
        RSTN      = 1'b0;
        KEY_PULSE = 1'b0;
        EVT_READY = 1'b0;
        OVF_CLR   = 1'b0;
        exp_q.delete();
        tick();
        tick();
        @(negedge CLK1K);
        RSTN = 1'b1;
        tick();
        cyc = 0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; KEY_PULSE = 1'b0; EVT_READY = 1'b0; OVF_CLR = 1'b0;
        #3;
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", EVT_VALID); end
        checks++; if (EVT_CODE !== 2'd0)  begin failures++; $display("FAIL rst_code got=%0d exp=0", EVT_CODE); end
        checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        checks++; if (OVERFLOW !== 1'b0)  begin failures++; $display("FAIL rst_ovf got=%b exp=0", OVERFLOW); end
        do_reset();
        go_to(5);
        checks++; if (EVT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL rst_release valid=%b busy=%b exp=0,0", EVT_VALID, BUSY);
        end
    endtask

    task automatic test_single();
        logic [1:0] e;
        do_reset();
        go_to(10);
        exp_q.push_back(2'd1);
        pulse();
        checks++; if (BUSY !== 1'b1)      begin failures++; $display("FAIL single_busy_rise cyc=%0d got=%b exp=1", cyc, BUSY); end
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL single_valid_early cyc=%0d got=%b exp=0", cyc, EVT_VALID); end
        go_to(260);
        checks++; if (BUSY !== 1'b1 || EVT_VALID !== 1'b0) begin
            failures++; $display("FAIL single_at_260 busy=%b valid=%b exp=1,0", BUSY, EVT_VALID);
        end
        tick();
        checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL single_valid_261 got=%b exp=1", EVT_VALID); end
        checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL single_busy_fall got=%b exp=0", BUSY); end
        e = exp_q.pop_front();
        checks++; if (EVT_CODE !== e)     begin failures++; $display("FAIL single_code got=%0d exp=%0d", EVT_CODE, e); end
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        checks++; if (EVT_VALID !== 1'b0 || EVT_CODE !== 2'd0) begin
            failures++; $display("FAIL single_popped valid=%b code=%0d exp=0,0", EVT_VALID, EVT_CODE);
        end
    endtask

    task automatic test_double();
        logic [1:0] e;
        int pops;
        do_reset();
        go_to(10);
        pulse();
        go_to(200);
        exp_q.push_back(2'd2);
        pulse();
        go_to(450);
        checks++; if (EVT_VALID !== 1'b0 || BUSY !== 1'b1) begin
            failures++; $display("FAIL double_at_450 valid=%b busy=%b exp=0,1", EVT_VALID, BUSY);
        end
        tick();
        checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL double_valid_451 got=%b exp=1", EVT_VALID); end
        e = exp_q.pop_front();
        checks++; if (EVT_CODE !== e)     begin failures++; $display("FAIL double_code got=%0d exp=%0d", EVT_CODE, e); end

        // gap of 251 cycles: two separate single clicks
        do_reset();
        go_to(10);
        exp_q.push_back(2'd1);
        pulse();
        go_to(261);
        checks++; if (EVT_VALID !== 1'b1 || BUSY !== 1'b0) begin
            failures++; $display("FAIL gap_first_closed valid=%b busy=%b exp=1,0", EVT_VALID, BUSY);
        end
        exp_q.push_back(2'd1);
        pulse();
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL gap_second_busy got=%b exp=1", BUSY); end
        go_to(512);
        pops = 0;
        EVT_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (EVT_VALID) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL gap_extra_event got=%0d exp=none", EVT_CODE);
                end else begin
                    e = exp_q.pop_front();
                    if (EVT_CODE !== e) begin failures++; $display("FAIL gap_code got=%0d exp=%0d", EVT_CODE, e); end
                end
            end
            tick();
        end
        EVT_READY = 1'b0;
        checks++; if (pops != 2) begin failures++; $display("FAIL gap_event_count got=%0d exp=2", pops); end
    endtask

    task automatic test_triple();
        logic [1:0] e;
        do_reset();
        go_to(10);
        pulse();
        go_to(100);
        pulse();
        go_to(190);
        exp_q.push_back(2'd3);
        pulse();
        checks++; if (EVT_VALID !== 1'b1 || BUSY !== 1'b0) begin
            failures++; $display("FAIL triple_at_191 valid=%b busy=%b exp=1,0", EVT_VALID, BUSY);
        end
        e = exp_q.pop_front();
        checks++; if (EVT_CODE !== e) begin failures++; $display("FAIL triple_code got=%0d exp=%0d", EVT_CODE, e); end
        // fourth pulse on the cycle after the close, popping the triple at the same time
        exp_q.push_back(2'd1);
        EVT_READY = 1'b1;
        pulse();
        EVT_READY = 1'b0;
        checks++; if (BUSY !== 1'b1 || EVT_VALID !== 1'b0) begin
            failures++; $display("FAIL triple_newgroup busy=%b valid=%b exp=1,0", BUSY, EVT_VALID);
        end
        go_to(441);
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL newgroup_early got=%b exp=0", EVT_VALID); end
        tick();
        e = exp_q.pop_front();
        checks++; if (EVT_VALID !== 1'b1 || EVT_CODE !== e) begin
            failures++; $display("FAIL newgroup_442 valid=%b code=%0d exp=1,%0d", EVT_VALID, EVT_CODE, e);
        end
    endtask

    task automatic test_collision();
        logic [1:0] e;
        do_reset();
        go_to(10);
        pulse();
        go_to(260);
        exp_q.push_back(2'd2);
        pulse();
        checks++; if (EVT_VALID !== 1'b0 || BUSY !== 1'b1) begin
            failures++; $display("FAIL collide_no_single valid=%b busy=%b exp=0,1", EVT_VALID, BUSY);
        end
        go_to(510);
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL collide_early got=%b exp=0", EVT_VALID); end
        tick();
        e = exp_q.pop_front();
        checks++; if (EVT_VALID !== 1'b1 || EVT_CODE !== e) begin
            failures++; $display("FAIL collide_code valid=%b code=%0d exp=1,%0d", EVT_VALID, EVT_CODE, e);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] e;
        int pops;
        int p;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            if (g < 4) exp_q.push_back(2'd1);
            pulse();
            repeat (251) tick();
            if (g == 3) begin
                checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_at_four got=%b exp=0", OVERFLOW); end
            end
        end
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", OVERFLOW); end
        pops = 0;
        EVT_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (EVT_VALID) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL ovf_extra_event got=%0d exp=none", EVT_CODE);
                end else begin
                    e = exp_q.pop_front();
                    if (EVT_CODE !== e) begin failures++; $display("FAIL ovf_drain_code got=%0d exp=%0d", EVT_CODE, e); end
                end
            end
            tick();
        end
        EVT_READY = 1'b0;
        checks++; if (pops != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", pops); end
        checks++; if (EVT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            failures++; $display("FAIL ovf_after_drain valid=%b ovf=%b exp=0,1", EVT_VALID, OVERFLOW);
        end
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); end

        // refill, then drop an event on a clearing cycle
        for (int g = 0; g < 4; g++) begin
            exp_q.push_back(2'd1);
            pulse();
            repeat (251) tick();
        end
        p = cyc;
        pulse();
        go_to(p + 250);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clr got=%b exp=1", OVERFLOW); end
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;

        // push coinciding with a pop while full
        p = cyc;
        pulse();
        go_to(p + 250);
        e = exp_q.pop_front();
        checks++; if (EVT_CODE !== e) begin failures++; $display("FAIL full_pop_code got=%0d exp=%0d", EVT_CODE, e); end
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        exp_q.push_back(2'd1);
        tick();
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf got=%b exp=0", OVERFLOW); end
        pops = 0;
        EVT_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (EVT_VALID) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL pushpop_extra_event got=%0d exp=none", EVT_CODE);
                end else begin
                    e = exp_q.pop_front();
                    if (EVT_CODE !== e) begin failures++; $display("FAIL pushpop_code got=%0d exp=%0d", EVT_CODE, e); end
                end
            end
            tick();
        end
        EVT_READY = 1'b0;
        checks++; if (pops != 4) begin failures++; $display("FAIL pushpop_count got=%0d exp=4", pops); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        for (int g = 0; g < 2; g++) begin
            exp_q.push_back(2'd1);
            pulse();
            repeat (251) tick();
        end
        pulse();
        repeat (20) tick();
        checks++; if (BUSY !== 1'b1 || EVT_VALID !== 1'b1) begin
            failures++; $display("FAIL mid_pre busy=%b valid=%b exp=1,1", BUSY, EVT_VALID);
        end
        #2;
        RSTN = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (EVT_VALID !== 1'b0 || EVT_CODE !== 2'd0) begin
            failures++; $display("FAIL mid_rst_fifo valid=%b code=%0d exp=0,0", EVT_VALID, EVT_CODE);
        end
        checks++; if (BUSY !== 1'b0 || OVERFLOW !== 1'b0) begin
            failures++; $display("FAIL mid_rst_ctrl busy=%b ovf=%b exp=0,0", BUSY, OVERFLOW);
        end
        @(negedge CLK1K);
        RSTN = 1'b1;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (EVT_VALID || BUSY) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_event cycles_active=%0d exp=0", seen); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        RSTN      = 1'b0;
        KEY_PULSE = 1'b0;
        EVT_READY = 1'b0;
        OVF_CLR   = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_triple();
        test_collision();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
